// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor run controller, the processor and the
// instruction memory.
//   - default widths for instruction memory address/data and the run counter
//   - default halt instruction word
//   - run controller state encoding
package proc_ctrl_pkg;

   localparam int          ADDR_W_DEF    = 10;
   localparam int          DATA_W_DEF    = 32;
   localparam int          CNT_W_DEF     = 16;
   localparam logic [31:0] HALT_INSN_DEF = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ARM    = 3'd2,
      ST_LAUNCH = 3'd3,
      ST_RUN    = 3'd4,
      ST_DONE   = 3'd5
   } run_state_e;

endpackage

// File: rtl/proc_run_ctrl_run_cycle_counter.sv
// Run-cycle counter for the processor run controller.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : synchronous clear (new session)
//   en          : count one RUN cycle
//   limit       : cycle limit, 0 = unlimited
//   count       : RUN cycles elapsed, saturates at all-ones
//   limit_hit   : this enabled cycle is the last one allowed (count+1 == limit)
module run_cycle_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             limit_hit
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

   // Compare one bit wider so a saturated count can never alias onto a limit.
   assign limit_hit = (limit != '0) &&
                      (({1'b0, count} + (CNT_W + 1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle processor.
// Streams a program into instruction memory from address 0, releases the
// processor from reset with a one-cycle load_pc pulse, then watches the
// fetched instruction for the halt word and enforces a run-cycle limit.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   start, abort                : session control
//   ld_valid/ld_ready/ld_data/ld_last : program word stream
//   imem_we/imem_addr/imem_wdata      : instruction memory write port
//   proc_reset, load_pc         : processor control
//   inst                        : instruction currently fetched
//   cycle_limit                 : max RUN cycles, 0 = unlimited
//   busy, done, halted, timeout, overflow, word_count, run_cycles : status
//
// state  | meaning
// IDLE   | no session, processor held in reset
// LOAD   | accepting program words into instruction memory
// ARM    | one cycle for the final memory write to settle
// LAUNCH | processor out of reset, load_pc pulsed
// RUN    | processor running, watching for halt / cycle limit
// DONE   | session finished, status held until next start
module proc_run_ctrl
   import proc_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                DATA_W    = DATA_W_DEF,
   parameter int                CNT_W     = CNT_W_DEF,
   parameter logic [DATA_W-1:0] HALT_INSN = DATA_W'(HALT_INSN_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              proc_reset,
   output logic              load_pc,
   input  logic [DATA_W-1:0] inst,
   input  logic [CNT_W-1:0]  cycle_limit,
   output logic              busy,
   output logic              done,
   output logic              halted,
   output logic              timeout,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count,
   output logic [CNT_W-1:0]  run_cycles
);

   localparam int WC_W = ADDR_W + 1;

   run_state_e state_q, state_d;

   logic accept;
   logic at_top;
   logic halt_seen;
   logic limit_hit;
   logic is_busy;
   logic start_sess;
   logic abort_sess;
   logic cnt_en;

   assign is_busy    = (state_q == ST_LOAD) || (state_q == ST_ARM) ||
                       (state_q == ST_LAUNCH) || (state_q == ST_RUN);
   assign start_sess = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign abort_sess = abort && is_busy;
   assign accept     = ld_ready && ld_valid;
   assign at_top     = (word_count[ADDR_W-1:0] == {ADDR_W{1'b1}});
   assign halt_seen  = (inst == HALT_INSN);
   assign cnt_en     = (state_q == ST_RUN) && !abort && !halt_seen;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (accept) begin
               if (ld_last)     state_d = ST_ARM;
               else if (at_top) state_d = ST_DONE;
            end
         end
         ST_ARM: begin
            state_d = abort ? ST_IDLE : ST_LAUNCH;
         end
         ST_LAUNCH: begin
            state_d = abort ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (abort)          state_d = ST_IDLE;
            else if (halt_seen) state_d = ST_DONE;
            else if (limit_hit) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Writes and the load_pc pulse are gated by reset so nothing reaches the
   // memory or processor on the reset edge itself.
   always_comb begin
      ld_ready   = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      proc_reset = 1'b1;
      load_pc    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         ST_LOAD: begin
            busy       = 1'b1;
            ld_ready   = !abort && !reset;
            imem_we    = !abort && !reset && ld_valid;
            imem_addr  = word_count[ADDR_W-1:0];
            imem_wdata = ld_data;
         end
         ST_ARM: begin
            busy = 1'b1;
         end
         ST_LAUNCH: begin
            busy       = 1'b1;
            proc_reset = reset;
            load_pc    = !reset;
         end
         ST_RUN: begin
            busy       = 1'b1;
            proc_reset = reset;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_count <= '0;
         halted     <= 1'b0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
      end else if (start_sess) begin
         word_count <= '0;
         halted     <= 1'b0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
      end else if (abort_sess) begin
         halted     <= 1'b0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (accept) begin
            word_count <= word_count + WC_W'(1);
            if (!ld_last && at_top) overflow <= 1'b1;
         end
         if (state_q == ST_RUN) begin
            if (halt_seen)      halted  <= 1'b1;
            else if (limit_hit) timeout <= 1'b1;
         end
      end
   end

   run_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_run_cycle_counter (
      .clk       (clk),
      .reset     (reset),
      .clr       (start_sess),
      .en        (cnt_en),
      .limit     (cycle_limit),
      .count     (run_cycles),
      .limit_hit (limit_hit)
   );

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Run controller for the single-cycle processor.
- Accepts a program as a valid/ready word stream and writes it into instruction memory from address 0.
- Releases the processor from reset and issues the one-cycle `load_pc` pulse.
- Monitors the fetched instruction for a halt word and enforces a run-cycle limit.
- Reports completion status. Replaces hand-driven reset/`load_pc` sequencing in benches and the system top.

Parameters:
ADDR_W, 10, instruction memory word-address width
DATA_W, 32, instruction width
CNT_W, 16, width of run-cycle counter and cycle_limit
HALT_INSN, 32'hFFFF_FFFF, fetched instruction value that ends a run

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
start  in  1  begin a load+run session (sampled in IDLE and DONE only)
abort  in  1  cancel session from LOAD/ARM/LAUNCH/RUN
ld_valid  in  1  program word valid
ld_ready  out  1  controller accepts program word
ld_data  in  DATA_W  program word
ld_last  in  1  final program word (qualified by ld_valid&ld_ready)
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
proc_reset  out  1  drives processor reset
load_pc  out  1  drives processor load_pc
inst  in  DATA_W  instruction currently fetched by processor
cycle_limit  in  CNT_W  max RUN cycles; 0 = unlimited
busy  out  1  high in LOAD/ARM/LAUNCH/RUN
done  out  1  high in DONE
halted  out  1  run ended on HALT_INSN
timeout  out  1  run ended on cycle_limit
overflow  out  1  load exceeded memory depth
word_count  out  ADDR_W+1  words written this session
run_cycles  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset values: state IDLE, ld_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, proc_reset 1, load_pc 0, busy 0, done 0, halted/timeout/overflow 0, word_count 0, run_cycles 0. Reset mid-session aborts immediately, no further imem writes.
- IDLE: proc_reset=1. If start=1, go to LOAD at the next edge; clear word_count, run_cycles and flags.
- LOAD: ld_ready=1, proc_reset=1.
  - Write is combinational on accept: imem_we=ld_valid, imem_addr=word_count[ADDR_W-1:0], imem_wdata=ld_data.
  - word_count increments at the edge of each accept.
  - Accept with ld_last=1 goes to ARM.
  - Accept at address 2^ADDR_W-1 with ld_last=0: that word is written, then overflow=1 and go to DONE (no run). The address never wraps.
- ARM: one cycle, proc_reset=1, ld_ready=0. Lets the final memory write settle. Next state LAUNCH.
- LAUNCH: one cycle, proc_reset=0, load_pc=1. Next state RUN.
- RUN: proc_reset=0, load_pc=0. Each cycle, in priority order:
  1. inst==HALT_INSN: halted=1, go to DONE, run_cycles not incremented.
  2. Otherwise run_cycles increments. If cycle_limit!=0 and run_cycles+1==cycle_limit: timeout=1, go to DONE.
- Halt and limit in the same cycle: halted=1, timeout=0.
- DONE: proc_reset=1, done=1. Flags, word_count and run_cycles are held. start=1 clears them and goes to LOAD.
- abort=1 in any busy state: go to IDLE next edge, proc_reset=1, flags cleared, counters held. abort has priority over all other transitions. abort is ignored in IDLE/DONE.
- start is ignored while busy. run_cycles saturates at all-ones when cycle_limit=0.
- Latency: last word accepted at edge n gives ARM in cycle n+1, LAUNCH (load_pc=1) in n+2, RUN from n+3.

Decomposition:
- Shared package proc_ctrl_pkg:
  - state encoding typedef (IDLE, LOAD, ARM, LAUNCH, RUN, DONE)
  - default HALT_INSN constant
  - ADDR_W/DATA_W defaults shared with processor and instruction memory
- One sub-module: run_cycle_counter. Holds the CNT_W counter with clear, enable, saturation, and limit-match output (limit=0 never matches).

Test Plan:
- Reset, start, 4 words (last on 4th), inst never halt, cycle_limit=10 -> imem writes at addr 0..3; load_pc high exactly one cycle at n+2 with proc_reset=0; timeout=1, run_cycles=10, word_count=4.
- Same load, inst=HALT_INSN on 3rd RUN cycle -> halted=1, timeout=0, run_cycles=2, done=1, proc_reset=1.
- cycle_limit=3 with HALT_INSN on 3rd RUN cycle -> halted=1, timeout=0 (halt priority).
- ADDR_W=2, stream 5 words with ld_last only on 5th -> 4 writes (addr 0..3), overflow=1, DONE, load_pc never pulses.
- ld_valid toggled 1/0 during LOAD -> writes only on valid cycles, addresses contiguous; then abort in RUN -> IDLE next edge, proc_reset=1; start pulses during RUN are ignored.
- Synchronous reset asserted mid-LOAD with ld_valid=1 -> no write on the reset edge onward; all outputs at reset values the following cycle.
